// File: rtl/fprint_gated_pio_pkg.sv
// -----------------------------------------------------------------------------
// fprint_gated_pio_pkg
// Shared types and helpers for the task-gated PIO commit buffer.
//   state_t     : controller states (IDLE / COLLECT / DRAIN)
//   CNT_W       : width of the optional statistics counters
//   clog2_safe  : index width that never collapses to zero bits
// -----------------------------------------------------------------------------
package fprint_gated_pio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  localparam int CNT_W = 16;

  // A single channel or single entry still needs a 1-bit index.
  function automatic int clog2_safe(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fprint_pio_fifo.sv
// -----------------------------------------------------------------------------
// fprint_pio_fifo
// Synchronous FIFO holding {src, data} entries of the commit buffer.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   push, wdata     : write an entry (ignored when full)
//   pop, rdata      : rdata shows the head entry; pop removes it (ignored when empty)
//   flush           : empty the FIFO; takes priority over push and pop
//   full, empty     : status flags
//   level           : number of entries held (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fprint_pio_fifo
  import fprint_gated_pio_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 5,
  localparam int PTR_W = clog2_safe(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [W-1:0]     wdata,
  input  logic             pop,
  output logic [W-1:0]     rdata,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (level_r == LVL_W'(DEPTH));
  assign empty     = (level_r == {LVL_W{1'b0}});
  assign level     = level_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign do_push_s = push & ~full & ~flush;
  assign do_pop_s  = pop & ~empty & ~flush;

  // Entry storage; contents need no reset because level gates visibility.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      level_r <= level_r + LVL_W'(do_push_s) - LVL_W'(do_pop_s);
    end
  end

endmodule

// File: rtl/fprint_gated_pio.sv
// -----------------------------------------------------------------------------
// fprint_gated_pio
// Task-gated PIO commit buffer. Redundant cores post PIO writes tagged with a
// task key; writes matching the active task are buffered and reach the PIO
// only after release_req, discard throws them away.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   task_set, task_key    : open a task (or restart the open one) with this key
//   task_busy             : high while committing; task_set is ignored then
//   release_req           : fingerprints matched, commit the buffer
//                           ("release" is a reserved word, hence the name)
//   discard               : fingerprints mismatched, flush the buffer
//   wr_valid/data/key     : per-channel write requests, channel 0 in LSBs
//   wr_ready              : per-channel accept (only the granted channel)
//   pio_out, pio_src      : committed PIO value and its source channel
//   pio_strobe            : 1-cycle pulse when pio_out updates
//   drop_pulse            : 1-cycle pulse after a key-mismatched write
//   fill_level            : entries currently held
// Optional build macro FPRINT_GPIO_STATS_EN adds drop_count/commit_count,
// saturating counters of dropped writes and PIO strobes.
// -----------------------------------------------------------------------------
module fprint_gated_pio
  import fprint_gated_pio_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 4,
  parameter int KEY_W  = 8,
  parameter int DEPTH  = 8,
  localparam int SRC_W = clog2_safe(NUM_CH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     task_set,
  input  logic [KEY_W-1:0]         task_key,
  output logic                     task_busy,
  input  logic                     release_req,
  input  logic                     discard,
  input  logic [NUM_CH-1:0]        wr_valid,
  input  logic [NUM_CH*DATA_W-1:0] wr_data,
  input  logic [NUM_CH*KEY_W-1:0]  wr_key,
  output logic [NUM_CH-1:0]        wr_ready,
  output logic [DATA_W-1:0]        pio_out,
  output logic                     pio_strobe,
  output logic [SRC_W-1:0]         pio_src,
  output logic                     drop_pulse,
  output logic [LVL_W-1:0]         fill_level
`ifdef FPRINT_GPIO_STATS_EN
  ,
  output logic [CNT_W-1:0]         drop_count,
  output logic [CNT_W-1:0]         commit_count
`endif
);

  localparam int ENT_W = SRC_W + DATA_W;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [KEY_W-1:0]   key_r;
  logic [SRC_W-1:0]   grant_idx_s;
  logic               grant_any_s;
  logic [KEY_W-1:0]   grant_key_s;
  logic [DATA_W-1:0]  grant_data_s;
  logic               key_match_s;
  logic               push_s;
  logic               pop_s;
  logic               flush_s;
  logic               drop_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [LVL_W-1:0]   fifo_level_s;
  logic [ENT_W-1:0]   fifo_rdata_s;

  // Fixed priority: the lowest-numbered requesting channel wins.
  function automatic logic [SRC_W-1:0] first_set(input logic [NUM_CH-1:0] v);
    logic [SRC_W-1:0] idx;
    idx = {SRC_W{1'b0}};
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = v[i] ? SRC_W'(i) : idx;
    end
    return idx;
  endfunction

  assign grant_any_s  = |wr_valid;
  assign grant_idx_s  = first_set(wr_valid);
  assign grant_key_s  = wr_key[int'(grant_idx_s) * KEY_W +: KEY_W];
  assign grant_data_s = wr_data[int'(grant_idx_s) * DATA_W +: DATA_W];
  assign key_match_s  = (grant_key_s == key_r);
  assign task_busy    = (state_r == ST_DRAIN);
  assign fill_level   = fifo_level_s;

  fprint_pio_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .wdata ({grant_idx_s, grant_data_s}),
    .pop   (pop_s),
    .rdata (fifo_rdata_s),
    .flush (flush_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (fifo_level_s)
  );

  // State register and active task key.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      key_r   <= {KEY_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (task_set && (state_r != ST_DRAIN)) begin
        key_r <= task_key;
      end
    end
  end

  // Next-state decode; task_set outranks discard, discard outranks release.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (task_set) begin
          state_nxt_s = ST_COLLECT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (task_set) begin
          state_nxt_s = ST_COLLECT;
        end else if (discard) begin
          state_nxt_s = ST_IDLE;
        end else if (release_req) begin
          // A write accepted on the release edge must still be committed.
          state_nxt_s = (!fifo_empty_s || push_s) ? ST_DRAIN : ST_IDLE;
        end else begin
          state_nxt_s = ST_COLLECT;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty_s || (pop_s && (fifo_level_s == LVL_W'(1'b1)))) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Per-state handshakes and buffer control.
  always_comb begin
    wr_ready = {NUM_CH{1'b0}};
    push_s   = 1'b0;
    pop_s    = 1'b0;
    flush_s  = 1'b0;
    drop_s   = 1'b0;
    case (state_r)
      ST_COLLECT: begin
        flush_s = task_set | discard;
        if (grant_any_s) begin
          if (key_match_s) begin
            // Full buffer backpressures rather than dropping.
            wr_ready[grant_idx_s] = ~fifo_full_s;
            push_s                = ~fifo_full_s;
          end else begin
            // Foreign-task writes are consumed and never stored.
            wr_ready[grant_idx_s] = 1'b1;
            drop_s                = 1'b1;
          end
        end else begin
          push_s = 1'b0;
        end
      end
      ST_DRAIN: begin
        pop_s = ~fifo_empty_s;
      end
      ST_IDLE: begin
        pop_s = 1'b0;
      end
      default: begin
        pop_s = 1'b0;
      end
    endcase
  end

  // PIO output registers; pio_out only moves together with pio_strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pio_out    <= {DATA_W{1'b0}};
      pio_src    <= {SRC_W{1'b0}};
      pio_strobe <= 1'b0;
      drop_pulse <= 1'b0;
    end else begin
      pio_strobe <= pop_s;
      drop_pulse <= drop_s;
      if (pop_s) begin
        pio_out <= fifo_rdata_s[DATA_W-1:0];
        pio_src <= fifo_rdata_s[ENT_W-1:DATA_W];
      end
    end
  end

`ifdef FPRINT_GPIO_STATS_EN
  // Saturating drop/commit statistics, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count   <= {CNT_W{1'b0}};
      commit_count <= {CNT_W{1'b0}};
    end else begin
      if (drop_pulse && (drop_count != {CNT_W{1'b1}})) begin
        drop_count <= drop_count + CNT_W'(1'b1);
      end
      if (pio_strobe && (commit_count != {CNT_W{1'b1}})) begin
        commit_count <= commit_count + CNT_W'(1'b1);
      end
    end
  end
`else
  // Statistics disabled: no counter ports or logic.
`endif

endmodule

// File: tb/tb_fprint_gated_pio.sv
// -----------------------------------------------------------------------------
// tb_fprint_gated_pio
// Directed self-checking bench for fprint_gated_pio (NUM_CH=2, DATA_W=4,
// KEY_W=8, DEPTH=8). Inputs change 1 ns after the rising edge; registered
// outputs are sampled there, combinational ones after a further 1 ns.
// -----------------------------------------------------------------------------
module tb_fprint_gated_pio;
  import fprint_gated_pio_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        task_set;
  logic [7:0]  task_key;
  logic        task_busy;
  logic        release_req;
  logic        discard;
  logic [1:0]  wr_valid;
  logic [7:0]  wr_data;
  logic [15:0] wr_key;
  logic [1:0]  wr_ready;
  logic [3:0]  pio_out;
  logic        pio_strobe;
  logic [0:0]  pio_src;
  logic        drop_pulse;
  logic [3:0]  fill_level;
`ifdef FPRINT_GPIO_STATS_EN
  logic [15:0] drop_count;
  logic [15:0] commit_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fprint_gated_pio dut (
    .clk         (clk),
    .reset       (reset),
    .task_set    (task_set),
    .task_key    (task_key),
    .task_busy   (task_busy),
    .release_req (release_req),
    .discard     (discard),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .wr_key      (wr_key),
    .wr_ready    (wr_ready),
    .pio_out     (pio_out),
    .pio_strobe  (pio_strobe),
    .pio_src     (pio_src),
    .drop_pulse  (drop_pulse),
    .fill_level  (fill_level)
`ifdef FPRINT_GPIO_STATS_EN
    ,
    .drop_count  (drop_count),
    .commit_count(commit_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; task_set = 1'b0; task_key = 8'h00; release_req = 1'b0;
    discard = 1'b0; wr_valid = 2'b11; wr_data = 8'h00; wr_key = 16'h0000;

    // ---------------- reset state
    #2;
    chk("rst_pio_out", pio_out, 0);
    chk("rst_strobe", pio_strobe, 0);
    chk("rst_src", pio_src, 0);
    chk("rst_drop", drop_pulse, 0);
    chk("rst_wr_ready", wr_ready, 2'b00);
    chk("rst_fill", fill_level, 0);
    chk("rst_busy", task_busy, 0);
    wr_valid = 2'b00;
    @(negedge clk); reset = 1'b0;
    step();

    // ---------------- basic commit: ch0 writes 3,5 under key 0x11
    task_set = 1'b1; task_key = 8'h11; step(); task_set = 1'b0;
    wr_valid = 2'b01; wr_data = 8'h03; wr_key = 16'h0011; #1;
    chk("basic_ready", wr_ready, 2'b01);
    step();
    chk("basic_fill1", fill_level, 1);
    wr_data = 8'h05; step();
    chk("basic_fill2", fill_level, 2);
    wr_valid = 2'b00; release_req = 1'b1; step(); release_req = 1'b0;
    chk("basic_busy", task_busy, 1);
    chk("basic_nostrobe_yet", pio_strobe, 0);
    step();
    chk("basic_strobe1", pio_strobe, 1);
    chk("basic_data1", pio_out, 4'h3);
    chk("basic_src1", pio_src, 0);
    step();
    chk("basic_strobe2", pio_strobe, 1);
    chk("basic_data2", pio_out, 4'h5);
    chk("basic_idle", task_busy, 0);
    chk("basic_fill0", fill_level, 0);
    step();
    chk("basic_strobe_end", pio_strobe, 0);
    chk("basic_hold", pio_out, 4'h5);

    // ---------------- key mismatch: ch1 writes 7 under key 0x22
    task_set = 1'b1; task_key = 8'h11; step(); task_set = 1'b0;
    wr_valid = 2'b10; wr_data = 8'h70; wr_key = 16'h2200; #1;
    chk("mis_ready", wr_ready, 2'b10);
    step(); wr_valid = 2'b00;
    chk("mis_drop", drop_pulse, 1);
    chk("mis_fill", fill_level, 0);
    step();
    chk("mis_drop_clr", drop_pulse, 0);
    release_req = 1'b1; step(); release_req = 1'b0;
    chk("mis_rel_idle", task_busy, 0);
    step();
    chk("mis_no_strobe", pio_strobe, 0);
    chk("mis_pio_hold", pio_out, 4'h5);
    wr_valid = 2'b01; wr_key = 16'h1111; #1;
    chk("idle_no_ready", wr_ready, 2'b00);
    wr_valid = 2'b00; step();

    // ---------------- arbitration and full: both channels, 10 cycles
    task_set = 1'b1; task_key = 8'h11; step(); task_set = 1'b0;
    wr_valid = 2'b11; wr_key = 16'h1111;
    for (int i = 0; i < 10; i++) begin
      wr_data = {4'h2, 4'(i)};
      #1;
      chk("full_ready", wr_ready, (i < 8) ? 2'b01 : 2'b00);
      step();
    end
    wr_valid = 2'b00;
    chk("full_fill", fill_level, 8);
    release_req = 1'b1; step(); release_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("full_drain_strobe", pio_strobe, 1);
      chk("full_drain_data", pio_out, i);
      chk("full_drain_src", pio_src, 0);
    end
    step();
    chk("full_drain_end", pio_strobe, 0);
    chk("full_drain_idle", task_busy, 0);

    // ---------------- discard wins over release: 3 entries from ch1
    task_set = 1'b1; task_key = 8'h11; step(); task_set = 1'b0;
    wr_valid = 2'b10; wr_key = 16'h1100;
    wr_data = 8'h90; step();
    wr_data = 8'hA0; step();
    wr_data = 8'hB0; step();
    wr_valid = 2'b00;
    chk("disc_fill3", fill_level, 3);
    release_req = 1'b1; discard = 1'b1; step(); release_req = 1'b0; discard = 1'b0;
    chk("disc_fill0", fill_level, 0);
    chk("disc_not_busy", task_busy, 0);
    chk("disc_no_strobe", pio_strobe, 0);
    step();
    chk("disc_no_strobe2", pio_strobe, 0);
    chk("disc_pio_hold", pio_out, 4'h7);
    wr_valid = 2'b01; wr_key = 16'h1111; #1;
    chk("disc_idle_ready", wr_ready, 2'b00);
    wr_valid = 2'b00; step();

    // ---------------- write accepted on the release edge is committed
    task_set = 1'b1; task_key = 8'h33; step(); task_set = 1'b0;
    wr_valid = 2'b10; wr_data = 8'hC0; wr_key = 16'h3300; release_req = 1'b1;
    step(); wr_valid = 2'b00; release_req = 1'b0;
    chk("reledge_busy", task_busy, 1);
    step();
    chk("reledge_strobe", pio_strobe, 1);
    chk("reledge_data", pio_out, 4'hC);
    chk("reledge_src", pio_src, 1);
    step();
    chk("reledge_end", pio_strobe, 0);
    chk("reledge_idle", task_busy, 0);

    // ---------------- task_set mid-COLLECT flushes and rekeys
    task_set = 1'b1; task_key = 8'h44; step(); task_set = 1'b0;
    wr_valid = 2'b01; wr_data = 8'h01; wr_key = 16'h0044; step(); wr_valid = 2'b00;
    chk("retask_fill1", fill_level, 1);
    task_set = 1'b1; task_key = 8'h55; step(); task_set = 1'b0;
    chk("retask_flush", fill_level, 0);
    wr_valid = 2'b01; wr_key = 16'h0044; step();
    chk("retask_old_key_drop", drop_pulse, 1);
    chk("retask_old_key_fill", fill_level, 0);
    wr_data = 8'h06; wr_key = 16'h0055; step(); wr_valid = 2'b00;
    chk("retask_new_key_fill", fill_level, 1);
    chk("retask_new_key_nodrop", drop_pulse, 0);
    release_req = 1'b1; step(); release_req = 1'b0;
    step();
    chk("retask_strobe", pio_strobe, 1);
    chk("retask_data", pio_out, 4'h6);
    step();
`ifdef FPRINT_GPIO_STATS_EN
    chk("stats_drops", drop_count, 2);
    chk("stats_commits", commit_count, 12);
`endif

    // ---------------- DRAIN ignores controls; reset mid-DRAIN
    task_set = 1'b1; task_key = 8'h66; step(); task_set = 1'b0;
    wr_valid = 2'b01; wr_key = 16'h0066;
    wr_data = 8'h01; step();
    wr_data = 8'h02; step();
    wr_data = 8'h03; step();
    wr_valid = 2'b00;
    release_req = 1'b1; step(); release_req = 1'b0;
    chk("drain_busy", task_busy, 1);
    task_set = 1'b1; task_key = 8'h77; discard = 1'b1; step();
    task_set = 1'b0; discard = 1'b0;
    chk("drain_ignore_strobe", pio_strobe, 1);
    chk("drain_ignore_data", pio_out, 4'h1);
    chk("drain_ignore_fill", fill_level, 2);
    chk("drain_ignore_busy", task_busy, 1);
    reset = 1'b1; #1;
    chk("rstdrain_pio", pio_out, 0);
    chk("rstdrain_strobe", pio_strobe, 0);
    chk("rstdrain_fill", fill_level, 0);
    chk("rstdrain_busy", task_busy, 0);
`ifdef FPRINT_GPIO_STATS_EN
    chk("rstdrain_drops", drop_count, 0);
    chk("rstdrain_commits", commit_count, 0);
`endif
    @(negedge clk); reset = 1'b0;
    step();
    chk("postrst_strobe", pio_strobe, 0);
    chk("postrst_pio", pio_out, 0);
    chk("postrst_fill", fill_level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
